vga_scan_timing: RTL and testbench
==================================

Name: vga_scan_timing

Overview:
- Raster scan generator that feeds the pixel colouring stage.
- Produces the current pixel coordinate pair (x, y), with bit 10 set outside the visible area, plus hsync/vsync aligned to the downstream colour output.
- Produces a once-per-frame pulse so the PE array can advance a generation during vertical blanking without tearing.

Parameters:
- H_VISIBLE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch, pixels
- H_SYNC, 136, hsync width, pixels
- H_BACK, 160, horizontal back porch, pixels
- V_VISIBLE, 768, visible lines per frame
- V_FRONT, 3, vertical front porch, lines
- V_SYNC, 6, vsync width, lines
- V_BACK, 29, vertical back porch, lines
- SYNC_ACTIVE, 0, asserted level of hsync/vsync
- SYNC_DELAY, 1, extra cycles hsync/vsync are delayed relative to x/y (range 0..7)
- GEN_DIV, 30, frames per generation tick (optional feature only)

Ports:
- clk, in, 1, pixel-domain clock
- rst, in, 1, asynchronous active-high reset
- pix_ce, in, 1, pixel clock enable; counters advance only when 1
- x, out, 11, horizontal coordinate; 11'h7FF outside the visible columns
- y, out, 11, vertical coordinate; 11'h7FF outside the visible lines
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- frame_done, out, 1, one-cycle pulse at start of vertical blanking
- gen_tick, out, 1, generation advance pulse (VGA_GEN_TICK_EN only)
- gen_pause, in, 1, hold gen_tick low (VGA_GEN_TICK_EN only)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Counter widths:
  - h_cnt and v_cnt are 11-bit internal counters.
  - H_TOTAL = sum of the four H parameters (1344); V_TOTAL = sum of the four V parameters (806).
- Counter advance, only on cycles with pix_ce=1:
  - h_cnt increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0.
  - pix_ce=0 holds every register, including the sync delay line and the frame divider.
- Outputs are registered from the counter values, one pix_ce cycle of latency:
  - x = h_cnt when h_cnt < H_VISIBLE, else 11'h7FF.
  - y = v_cnt when v_cnt < V_VISIBLE, else 11'h7FF.
- Sync windows:
  - hsync is raw-asserted for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync is raw-asserted for V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC.
  - Assertion is on whole lines; vsync changes at h_cnt=0.
  - Raw syncs pass through a (1+SYNC_DELAY)-stage shift register clocked by pix_ce.
  - SYNC_DELAY=1 matches the one-cycle state fetch of the PE array plus the combinational colour stage.
- frame_done:
  - High for exactly one clk cycle.
  - Fires on the pix_ce cycle where the registered outputs first show v_cnt=V_VISIBLE, h_cnt=0.
  - Never high during visible lines.
- Reset:
  - h_cnt=0, v_cnt=0.
  - x=0, y=0.
  - hsync=vsync=~SYNC_ACTIVE, and every delay stage is filled with ~SYNC_ACTIVE.
  - frame_done=0, gen_tick=0, frame divider=0.
- Reset mid-frame: all outputs return to the reset values immediately (asynchronously). The scan restarts at pixel (0,0) on the first pix_ce after release.
- Boundary conditions:
  - At the last pixel of the last line (h=H_TOTAL-1, v=V_TOTAL-1), both counters wrap in the same cycle to (0,0).
  - frame_done must not fire on that wrap.

Optional Feature:
- Macro: VGA_GEN_TICK_EN.
- Defined:
  - A frame divider counts frame_done pulses from 0 to GEN_DIV-1.
  - On the pulse that wraps it to 0, gen_tick fires coincident with frame_done, unless gen_pause=1.
  - While gen_pause=1 the divider keeps counting but gen_tick stays low.
- Undefined:
  - gen_tick is tied 0, and the gen_pause input is ignored.
  - The divider logic is absent.

Decomposition:
- vga_timing_pkg holds:
  - The 1024x768@60 timing localparams and the H_TOTAL/V_TOTAL derivations.
  - The COORD_W=11 constant.
  - The OFFSCREEN=11'h7FF constant.
- One sub-module: sync_delay, a parameterised depth shift register with reset value and clock enable, instantiated for hsync and vsync.

Test Plan:
- rst high with pix_ce=1 for 10 cycles -> x=0, y=0, hsync=vsync=1, frame_done=0 throughout.
- After release, count pix_ce cycles along line 0:
  - x steps 0..1023.
  - x=7FF from h=1024 to 1343.
  - With SYNC_DELAY=1, hsync low for exactly 136 cycles, first low 2 cycles after h_cnt=1048.
- Full frame:
  - vsync low for exactly 6*1344 pix_ce cycles starting at line 771.
  - y=7FF on lines 768..805.
  - frame_done pulses exactly once, at (h=0, v=768).
  - Repeats every 1344*806 = 1083264 pix_ce cycles.
- pix_ce toggling 1,0,1,0 -> x advances one per enabled cycle; frame period doubles to 2166528 clk cycles; frame_done still one clk wide.
- Assert rst at x=500, y=300 -> outputs go to reset values in the same cycle; after release the scan restarts at x=0, y=0.
- VGA_GEN_TICK_EN with GEN_DIV=3:
  - gen_tick on frames 3, 6, 9.
  - gen_pause=1 during frame 6 -> tick suppressed there, tick still at frame 9.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1024x768@60 raster constants and small helpers shared by
// the scan timing block.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 11;
  localparam logic [COORD_W-1:0] OFFSCREEN = 11'h7FF;

  localparam int unsigned VGA_H_VISIBLE = 1024;
  localparam int unsigned VGA_H_FRONT   = 24;
  localparam int unsigned VGA_H_SYNC    = 136;
  localparam int unsigned VGA_H_BACK    = 160;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int unsigned VGA_V_VISIBLE = 768;
  localparam int unsigned VGA_V_FRONT   = 3;
  localparam int unsigned VGA_V_SYNC    = 6;
  localparam int unsigned VGA_V_BACK    = 29;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Counter value while inside the visible area, OFFSCREEN marker otherwise.
  function automatic logic [COORD_W-1:0] visible_coord(input logic [COORD_W-1:0] cnt,
                                                       input logic [COORD_W-1:0] limit);
    return (cnt < limit) ? cnt : OFFSCREEN;
  endfunction

  // Map "inside the sync window" onto the configured electrical level.
  function automatic logic sync_level(input logic in_window, input logic active);
    return in_window ? active : ~active;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// sync_delay: DEPTH-stage shift register with clock enable; reset fills
// every stage with RST_VAL so the output is idle immediately.
module sync_delay #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift one stage per enabled pixel; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= {DEPTH{RST_VAL}};
    end else if (ce) begin
      stages[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster scan generator producing pixel coordinates,
// delayed hsync/vsync and a per-frame pulse at the start of vertical blanking.
// Optional generation divider enabled by defining VGA_GEN_TICK_EN.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned SYNC_DELAY  = 1,
  parameter int unsigned GEN_DIV     = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_done,
  output logic               gen_tick,
  input  logic               gen_pause
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam int unsigned SYNC_DEPTH = 1 + SYNC_DELAY;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_last;
  logic               v_last;
  logic               frame_start;
  logic               hsync_raw;
  logic               vsync_raw;

  assign h_last      = (h_cnt == H_LAST);
  assign v_last      = (v_cnt == V_LAST);
  assign frame_start = (h_cnt == '0) && (v_cnt == V_VIS_C);

  // Raw sync levels; vsync follows v_cnt so it switches on whole lines at h_cnt=0.
  always_comb begin
    hsync_raw = sync_level((h_cnt >= HS_START) && (h_cnt < HS_END), SYNC_ACTIVE);
    vsync_raw = sync_level((v_cnt >= VS_START) && (v_cnt < VS_END), SYNC_ACTIVE);
  end

  // Pixel/line counters; both wrap together at the last pixel of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  end

  // Registered coordinates and frame pulse. frame_done is cleared on every
  // clk that is not the qualifying enabled cycle, so it stays one clk wide
  // even when pix_ce is slower than clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pix_ce && frame_start;
      if (pix_ce) begin
        x <= visible_coord(h_cnt, H_VIS_C);
        y <= visible_coord(v_cnt, V_VIS_C);
      end
    end
  end

  sync_delay #(
    .DEPTH   (SYNC_DEPTH),
    .RST_VAL (~SYNC_ACTIVE)
  ) u_hsync_delay (
    .clk (clk),
    .rst (rst),
    .ce  (pix_ce),
    .d   (hsync_raw),
    .q   (hsync)
  );

  sync_delay #(
    .DEPTH   (SYNC_DEPTH),
    .RST_VAL (~SYNC_ACTIVE)
  ) u_vsync_delay (
    .clk (clk),
    .rst (rst),
    .ce  (pix_ce),
    .d   (vsync_raw),
    .q   (vsync)
  );

`ifdef VGA_GEN_TICK_EN
  localparam int unsigned DIV_W = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GEN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Frame divider; the wrapping frame raises gen_tick alongside frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      gen_tick <= 1'b0;
    end else begin
      gen_tick <= 1'b0;
      if (pix_ce && frame_start) begin
        div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        gen_tick <= (div_cnt == DIV_LAST) && !gen_pause;
      end
    end
  end
`else
  logic unused_gen_pause;

  assign unused_gen_pause = gen_pause;
  assign gen_tick         = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: directed bench for vga_scan_timing. One instance uses
// the 1024x768 timing, a second uses a tiny raster so whole frames are short.
module tb_vga_scan_timing;

`ifdef VGA_GEN_TICK_EN
  localparam bit TICK_EN = 1'b1;
`else
  localparam bit TICK_EN = 1'b0;
`endif

  // Tiny raster: 8+2+3+3 = 16 pixels/line, 6+1+2+2 = 11 lines, 176 pixels/frame.
  localparam int S_FRAME = 176;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b1;
  logic        gen_pause = 1'b0;

  logic [10:0] d_x, d_y, s_x, s_y;
  logic        d_hs, d_vs, d_fd, d_gt;
  logic        s_hs, s_vs, s_fd, s_gt;

  int errors = 0;
  int checks = 0;
  int k      = 0;   // enabled pixel edges since reset release
  int cyc    = 0;
  bit pause_en = 1'b1;

  always #5 clk = ~clk;

  vga_scan_timing u_dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .x          (d_x),
    .y          (d_y),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .frame_done (d_fd),
    .gen_tick   (d_gt),
    .gen_pause  (gen_pause)
  );

  vga_scan_timing #(
    .H_VISIBLE   (8),
    .H_FRONT     (2),
    .H_SYNC      (3),
    .H_BACK      (3),
    .V_VISIBLE   (6),
    .V_FRONT     (1),
    .V_SYNC      (2),
    .V_BACK      (2),
    .SYNC_ACTIVE (1'b0),
    .SYNC_DELAY  (1),
    .GEN_DIV     (3)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .x          (s_x),
    .y          (s_y),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .frame_done (s_fd),
    .gen_tick   (s_gt),
    .gen_pause  (gen_pause)
  );

  task automatic cmp(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s cyc=%0d k=%0d observed=%0h expected=%0h", tag, what, cyc, k, obs, exp);
    end
  endtask

  // Expected outputs after kk enabled edges: the registered outputs show the
  // counter position kk-1, the sync outputs show the position kk-2.
  task automatic chk(input string tag, input logic [10:0] ox, input logic [10:0] oy,
                     input logic ohs, input logic ovs, input logic ofd, input logic ogt,
                     input int kk, input bit en,
                     input int hv, input int ht, input int hs0, input int hs1,
                     input int vv, input int vt, input int vs0, input int vs1,
                     input bit gt_ok);
    int p, h, v;
    logic [10:0] ex, ey;
    logic ehs, evs, efd, egt;
    ex = '0; ey = '0; ehs = 1'b1; evs = 1'b1; efd = 1'b0;
    if (kk >= 1) begin
      p = (kk - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      ex = (h < hv) ? 11'(h) : 11'h7FF;
      ey = (v < vv) ? 11'(v) : 11'h7FF;
      efd = en && (h == 0) && (v == vv);
    end
    if (kk >= 2) begin
      p = (kk - 2) % (ht * vt);
      h = p % ht;
      v = p / ht;
      ehs = !((h >= hs0) && (h < hs1));
      evs = !((v >= vs0) && (v < vs1));
    end
    egt = efd && gt_ok;
    cmp(tag, "x", 32'(ox), 32'(ex));
    cmp(tag, "y", 32'(oy), 32'(ey));
    cmp(tag, "hsync", 32'(ohs), 32'(ehs));
    cmp(tag, "vsync", 32'(ovs), 32'(evs));
    cmp(tag, "frame_done", 32'(ofd), 32'(efd));
    cmp(tag, "gen_tick", 32'(ogt), 32'(egt));
  endtask

  task automatic check_both(input bit en, input bit pz);
    bit gt_ok;
    gt_ok = TICK_EN && (k >= 1) && ((((k - 1) / S_FRAME) + 1) % 3 == 0) && !pz;
    chk("dflt", d_x, d_y, d_hs, d_vs, d_fd, d_gt, k, en,
        1024, 1344, 1048, 1184, 768, 806, 771, 777, 1'b0);
    chk("small", s_x, s_y, s_hs, s_vs, s_fd, s_gt, k, en,
        8, 16, 10, 13, 6, 11, 7, 9, gt_ok);
  endtask

  task automatic step(input bit ce);
    bit en, pz;
    pix_ce    = ce;
    gen_pause = pause_en && (k >= 880) && (k < 1056);
    pz        = gen_pause;
    en        = ce && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (en) k++;
    check_both(en, pz);
  endtask

  // Raise rst between clock edges and check outputs drop without an edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    k = 0;
    pause_en = 1'b0;
    check_both(1'b0, 1'b0);
    repeat (3) step(1'b1);
    rst = 1'b0;
  endtask

  initial begin
    int hs_low, hs_first, fd_cnt, vs_low, gt_cnt, last_fd, period;
    hs_low = 0; hs_first = -1; fd_cnt = 0; vs_low = 0; gt_cnt = 0;
    last_fd = -1; period = 0;

    // Reset held with pix_ce=1.
    repeat (10) step(1'b1);
    rst = 1'b0;

    // Continuous pixel enable: line 0 of the full raster, ~7.6 tiny frames.
    for (int i = 0; i < 1346; i++) begin
      step(1'b1);
      if (!d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (s_fd) fd_cnt++;
      if (s_gt) gt_cnt++;
      if (k >= 178 && k <= 353 && !s_vs) vs_low++;
    end
    cmp("line0", "hsync_low_cycles", 32'(hs_low), 32'd136);
    cmp("line0", "hsync_first_low_k", 32'(hs_first), 32'd1050);
    cmp("small", "frame_done_count", 32'(fd_cnt), 32'd8);
    cmp("small", "vsync_low_cycles", 32'(vs_low), 32'd32);

    // pix_ce toggling 1,0: frame period in clk cycles doubles.
    for (int i = 0; i < 400; i++) begin
      step(1'b1);
      if (s_fd) begin
        if (last_fd >= 0) period = cyc - last_fd;
        last_fd = cyc;
      end
      if (s_gt) gt_cnt++;
      step(1'b0);
      if (s_fd) begin
        if (last_fd >= 0) period = cyc - last_fd;
        last_fd = cyc;
      end
    end
    cmp("toggle", "frame_period_clk", 32'(period), 32'd352);
    cmp("gen", "gen_tick_count", 32'(gt_cnt), TICK_EN ? 32'd2 : 32'd0);

    // Reset mid-line with the full raster at x=500.
    for (int i = 0; i < 2000 && ((k - 1) % 1344) != 500; i++) step(1'b1);
    cmp("mid", "x_before_reset", 32'(d_x), 32'd500);
    async_reset();

    // Reset mid-frame with the tiny raster at (5,3).
    for (int i = 0; i < 54; i++) step(1'b1);
    cmp("mid", "small_x_before_reset", 32'(s_x), 32'd5);
    cmp("mid", "small_y_before_reset", 32'(s_y), 32'd3);
    async_reset();

    repeat (40) step(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
